// File: rtl/dac_hpf_mult_arbiter_if.sv
// rtl/dac_hpf_mult_arbiter_if.sv - requester and shared-multiplier signals of the HPF multiplier arbiter
//
// Signals:
//   arb_en     1 = new grants allowed
//   req        per-requester request level
//   req_a      packed signed operand A, requester i at [18i+17:18i]
//   req_b      packed signed operand B, requester i at [18i+17:18i]
//   gnt        one-hot grant pulse
//   mult_a     operand A to the shared multiplier
//   mult_b     operand B to the shared multiplier
//   mult_p     product returned by the shared multiplier
//   rsp_valid  one-hot result strobe
//   rsp_p      product returned to the owner of rsp_valid
//   busy       an operation is pending or in flight
// Modports:
//   slave   arbiter view
//   master  requesters plus multiplier view
interface dac_hpf_mult_arbiter_if #(
  parameter int N_REQ = 8
);
  logic                 arb_en;
  logic [N_REQ-1:0]     req;
  logic [18*N_REQ-1:0]  req_a;
  logic [18*N_REQ-1:0]  req_b;
  logic [N_REQ-1:0]     gnt;
  logic [17:0]          mult_a;
  logic [17:0]          mult_b;
  logic [35:0]          mult_p;
  logic [N_REQ-1:0]     rsp_valid;
  logic [35:0]          rsp_p;
  logic                 busy;

  modport slave (
    input  arb_en, req, req_a, req_b, mult_p,
    output gnt, mult_a, mult_b, rsp_valid, rsp_p, busy
  );

  modport master (
    output arb_en, req, req_a, req_b, mult_p,
    input  gnt, mult_a, mult_b, rsp_valid, rsp_p, busy
  );
endinterface

// File: rtl/dac_hpf_mult_arbiter.sv
// rtl/dac_hpf_mult_arbiter.sv - round-robin time-sharing of one pipelined 18x18 multiplier between HPF channels
//
// Ports:
//   dataclk  clock, all state on the rising edge
//   reset    synchronous active-high reset
//   bus      slave side of dac_hpf_mult_arbiter_if
//            in : arb_en, req, req_a, req_b, mult_p
//            out: gnt, mult_a, mult_b, rsp_valid, rsp_p, busy
module dac_hpf_mult_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MULT_LAT = 1
) (
  input  logic                  dataclk,
  input  logic                  reset,
  dac_hpf_mult_arbiter_if.slave bus
);

  // Requester index width is fixed at 3 bits so up to 8 channels fit one tag.
  localparam int IW = 3;

  logic [IW-1:0]       ptr;
  logic [N_REQ-1:0]    pending;
  logic                gnt_v;
  logic [IW-1:0]       gnt_idx;
  logic [MULT_LAT-1:0] tag_v;
  logic [IW-1:0]       tag_idx [MULT_LAT];

  logic [N_REQ-1:0]    eligible;
  logic [2*N_REQ-1:0]  elig_rot;
  logic                grant_hit;
  logic [IW-1:0]       grant_idx;
  int                  grant_sum;
  logic [N_REQ-1:0]    grant_onehot;
  logic [17:0]         grant_a;
  logic [17:0]         grant_b;
  logic                rsp_fire;
  logic [N_REQ-1:0]    rsp_onehot;
  logic [N_REQ-1:0]    pending_nxt;
  logic [IW-1:0]       ptr_nxt;

  // Round-robin search: rotating the doubled eligible vector by ptr puts
  // requester (ptr+off) mod N_REQ at bit off, so the lowest set bit wins.
  always_comb begin
    eligible  = bus.req & ~pending & {N_REQ{bus.arb_en}};
    elig_rot  = {eligible, eligible} >> ptr;
    grant_hit = 1'b0;
    grant_idx = '0;
    grant_sum = 0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!grant_hit && elig_rot[off]) begin
        grant_hit = 1'b1;
        grant_sum = int'(ptr) + off;
        if (grant_sum >= N_REQ) grant_sum = grant_sum - N_REQ;
        grant_idx = grant_sum[IW-1:0];
      end
    end
  end

  // Operand mux, one-hot decode of grant and returning tag, next pending/ptr.
  always_comb begin
    grant_onehot = '0;
    rsp_onehot   = '0;
    grant_a      = '0;
    grant_b      = '0;
    rsp_fire     = tag_v[MULT_LAT-1];
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_hit && grant_idx == IW'(i)) begin
        grant_onehot[i] = 1'b1;
        grant_a         = bus.req_a[18*i +: 18];
        grant_b         = bus.req_b[18*i +: 18];
      end
      if (rsp_fire && tag_idx[MULT_LAT-1] == IW'(i)) rsp_onehot[i] = 1'b1;
    end
    // A requester is never granted while pending, so set and clear of the
    // same bit cannot collide on one edge.
    pending_nxt = (pending & ~rsp_onehot) | grant_onehot;
    ptr_nxt     = ptr;
    if (grant_hit) ptr_nxt = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      ptr           <= '0;
      pending       <= '0;
      gnt_v         <= 1'b0;
      gnt_idx       <= '0;
      tag_v         <= '0;
      for (int s = 0; s < MULT_LAT; s++) tag_idx[s] <= '0;
      bus.gnt       <= '0;
      bus.mult_a    <= '0;
      bus.mult_b    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_p     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      ptr        <= ptr_nxt;
      pending    <= pending_nxt;
      gnt_v      <= grant_hit;
      gnt_idx    <= grant_idx;
      bus.gnt    <= grant_onehot;
      bus.mult_a <= grant_a;
      bus.mult_b <= grant_b;

      // Tag stage s lines up with the multiplier's stage s; the last stage
      // is valid in the cycle mult_p carries that requester's product.
      tag_v[0]   <= gnt_v;
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s < MULT_LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end

      bus.rsp_valid <= rsp_onehot;
      if (rsp_fire) bus.rsp_p <= bus.mult_p;

      // The result-delivery cycle still counts as busy even though its
      // pending bit has already dropped.
      bus.busy <= (|pending_nxt) | rsp_fire;
    end
  end

endmodule
